// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between a variable-latency
// instruction memory and decode.
//
// Requests go out on a valid/ready port. Responses come back in order and
// are tagged with the PC the queue expects next. A redirect flushes the
// buffered entries. It also records how many in-flight responses are stale,
// so that those responses are dropped when they arrive.
//
// Handshake semantics (both ports): a transfer happens in a cycle where
// valid and ready are both high at the rising edge. The request port may
// withdraw valid without a transfer, for example on a redirect or when
// credit runs out. While a request is pending and no redirect occurs,
// o_req_addr stays stable. The decode port is valid whenever the queue is
// non-empty, and the head is consumed when i_ready is high.
module fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    // instruction memory request port
    output logic              o_req_valid,
    output logic [ADDR_W-1:0] o_req_addr,
    input  logic              i_req_ready,
    // instruction memory response port (in order, no back-pressure)
    input  logic              i_rsp_valid,
    input  logic [DATA_W-1:0] i_rsp_data,
    // decode port
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data_instr,
    output logic [ADDR_W-1:0] o_addr_pc,
    output logic [ADDR_W-1:0] o_addr_pc4,
    input  logic              i_ready,
    // redirect from branch/jump resolution
    input  logic              i_con_redirect,
    input  logic [ADDR_W-1:0] i_addr_redirect
);

    // Pointer width, counter width (holds 0..DEPTH), and a wider width
    // for occupancy sums so that they cannot overflow.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    // Fetch addresses: the next address to request, and the PC that the
    // next non-stale response belongs to.
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] rsp_pc;

    // Circular buffer storage for the queued instructions and their PCs.
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    // Occupancy and in-flight accounting.
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;

    // Combinational control terms.
    logic [SW-1:0]     live_sum;
    logic              credit_ok;
    logic              req_valid;
    logic              req_fire;
    logic              rsp_drop;
    logic              push;
    logic              head_valid;
    logic              pop;

    // Credit and handshake decode. The live sum covers the slots already
    // filled plus the responses that will still land in the queue. Stale
    // responses are subtracted because they never occupy a slot.
    always_comb begin
        live_sum   = SW'(count) + SW'(outstanding) - SW'(drop_cnt);
        credit_ok  = (outstanding < CW'(DEPTH)) && (live_sum < SW'(DEPTH));
        req_valid  = i_nrst && !i_con_redirect && credit_ok;
        req_fire   = req_valid && i_req_ready;
        rsp_drop   = i_rsp_valid && ((drop_cnt != '0) || i_con_redirect);
        push       = i_rsp_valid && !rsp_drop;
        head_valid = i_nrst && (count != '0);
        pop        = head_valid && i_ready && !i_con_redirect;
    end

    // Output drive. The head fields are read straight from the read
    // pointer, so they are meaningless while o_valid is low.
    always_comb begin
        o_req_valid  = req_valid;
        o_req_addr   = req_pc;
        o_valid      = head_valid;
        o_data_instr = instr_mem[rd_ptr];
        o_addr_pc    = pc_mem[rd_ptr];
        o_addr_pc4   = pc_mem[rd_ptr] + ADDR_W'(4);
    end

    // Request address: a redirect reloads it, and a transfer advances it.
    // The add wraps modulo 2^ADDR_W.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            req_pc <= RESET_PC;
        end else if (i_con_redirect) begin
            req_pc <= i_addr_redirect;
        end else if (req_fire) begin
            req_pc <= req_pc + ADDR_W'(4);
        end
    end

    // Response PC tag: it follows the request stream, but only advances
    // for responses that are kept.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            rsp_pc <= RESET_PC;
        end else if (i_con_redirect) begin
            rsp_pc <= i_addr_redirect;
        end else if (push) begin
            rsp_pc <= rsp_pc + ADDR_W'(4);
        end
    end

    // Queue storage write. This is a plain RAM and needs no reset, because
    // o_valid qualifies every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= i_rsp_data;
            pc_mem[wr_ptr]    <= rsp_pc;
        end
    end

    // Queue pointers and count. A redirect clears them. A push and a pop
    // in the same cycle move both pointers and leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (!i_nrst || i_con_redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // In-flight accounting. Every response retires one outstanding
    // request. On a redirect, every request still in flight after this
    // cycle's response becomes stale.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (i_con_redirect) begin
            outstanding <= outstanding - CW'(i_rsp_valid);
            drop_cnt    <= outstanding - CW'(i_rsp_valid);
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(i_rsp_valid);
            if (i_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // The credit check must make a push into a full queue impossible.
    a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_nrst)
        !(push && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table, hand-written corner sequences and
// randomized traffic for fetch_queue, all checked against a queue-level
// reference model of the fetch stream.
module tb_fetch_queue;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    // ---------------- clock / reset / DUT ----------------
    logic              i_clk = 1'b0;
    logic              i_nrst;
    logic              o_req_valid;
    logic [ADDR_W-1:0] o_req_addr;
    logic              i_req_ready;
    logic              i_rsp_valid;
    logic [DATA_W-1:0] i_rsp_data;
    logic              o_valid;
    logic [DATA_W-1:0] o_data_instr;
    logic [ADDR_W-1:0] o_addr_pc;
    logic [ADDR_W-1:0] o_addr_pc4;
    logic              i_ready;
    logic              i_con_redirect;
    logic [ADDR_W-1:0] i_addr_redirect;

    always #5 i_clk = ~i_clk;

    fetch_queue #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk           (i_clk),
        .i_nrst          (i_nrst),
        .o_req_valid     (o_req_valid),
        .o_req_addr      (o_req_addr),
        .i_req_ready     (i_req_ready),
        .i_rsp_valid     (i_rsp_valid),
        .i_rsp_data      (i_rsp_data),
        .o_valid         (o_valid),
        .o_data_instr    (o_data_instr),
        .o_addr_pc       (o_addr_pc),
        .o_addr_pc4      (o_addr_pc4),
        .i_ready         (i_ready),
        .i_con_redirect  (i_con_redirect),
        .i_addr_redirect (i_addr_redirect)
    );

    // ---------------- reference model state ----------------
    // Memory: in-order list of accepted requests, each tagged with the
    // fetch epoch it was issued in and the cycle its response is due.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        bit          nrst;
        bit          ready;
        bit          req_ready;
        bit          e_rv;
        logic [31:0] e_ra;
        bit          e_v;
        logic [31:0] e_pc;
    } vec_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];     // PCs buffered for decode, head first
    int          cur_epoch;
    logic [31:0] m_req_pc;
    int          cyc;
    int          mem_lat;
    int          checks;
    int          errors;

    // outputs sampled in the most recent step
    logic        s_valid;
    logic        s_rv;
    logic [31:0] s_ra;
    logic [31:0] s_pc;
    logic [31:0] s_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE_5A5A;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input bit nrst, input bit rdy, input bit rrdy, input bit redir,
                        input logic [31:0] raddr, input bit rsp_allow,
                        input bit use_vec, input vec_t v);
        int    live;
        bit    e_rv;
        bit    e_v;
        bit    rsp_v;
        bit    fire;
        bit    keep;
        pend_t e;
        i_nrst          = nrst;
        i_ready         = rdy;
        i_req_ready     = rrdy;
        i_con_redirect  = redir;
        i_addr_redirect = raddr;
        rsp_v = 1'b0;
        if (nrst && rsp_allow && pend.size() > 0) begin
            if (pend[0].due <= cyc) rsp_v = 1'b1;
        end
        i_rsp_valid = rsp_v;
        if (rsp_v) i_rsp_data = mem_word(pend[0].addr);
        else       i_rsp_data = $urandom;

        @(negedge i_clk);
        live = 0;
        foreach (pend[k]) if (pend[k].epoch == cur_epoch) live++;
        e_rv = nrst && !redir && (pend.size() < DEPTH) && (exp_q.size() + live < DEPTH);
        e_v  = nrst && (exp_q.size() != 0);
        s_valid = o_valid;
        s_rv    = o_req_valid;
        s_ra    = o_req_addr;
        s_pc    = o_addr_pc;
        s_data  = o_data_instr;

        chk("req_valid", 32'(o_req_valid), 32'(e_rv));
        if (e_rv) chk("req_addr", o_req_addr, m_req_pc);
        chk("valid", 32'(o_valid), 32'(e_v));
        if (e_v && o_valid) begin
            chk("head_pc", o_addr_pc, exp_q[0]);
            chk("head_pc4", o_addr_pc4, exp_q[0] + 32'd4);
            chk("head_instr", o_data_instr, mem_word(exp_q[0]));
        end
        if (use_vec) begin
            chk("vec_req_valid", 32'(o_req_valid), 32'(v.e_rv));
            if (v.e_rv) chk("vec_req_addr", o_req_addr, v.e_ra);
            chk("vec_valid", 32'(o_valid), 32'(v.e_v));
            if (v.e_v) chk("vec_pc", o_addr_pc, v.e_pc);
        end

        // model update at the coming edge
        if (!nrst) begin
            pend.delete();
            exp_q.delete();
            m_req_pc = RESET_PC;
            cur_epoch++;
        end else begin
            fire = e_rv && rrdy;
            keep = 1'b0;
            if (rsp_v) begin
                e    = pend.pop_front();
                keep = !redir && (e.epoch == cur_epoch);
            end
            if (redir) begin
                exp_q.delete();
                cur_epoch++;
                m_req_pc = raddr;
            end else begin
                if (e_v && rdy) void'(exp_q.pop_front());
                if (keep) begin
                    chk("queue_room", 32'(exp_q.size() < DEPTH), 32'd1);
                    exp_q.push_back(e.addr);
                end
            end
            if (fire) begin
                pend.push_back('{m_req_pc, cur_epoch, cyc + mem_lat});
                m_req_pc = m_req_pc + 32'd4;
            end
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    vec_t nv;

    task automatic go(input bit nrst, input bit rdy, input bit rrdy, input bit redir,
                      input logic [31:0] raddr);
        step(nrst, rdy, rrdy, redir, raddr, 1'b1, 1'b0, nv);
    endtask

    function automatic vec_t mk(input bit nrst, input bit rdy, input bit rrdy,
                                input bit e_rv, input logic [31:0] e_ra,
                                input bit e_v, input logic [31:0] e_pc);
        vec_t r;
        r.nrst      = nrst;
        r.ready     = rdy;
        r.req_ready = rrdy;
        r.e_rv      = e_rv;
        r.e_ra      = e_ra;
        r.e_v       = e_v;
        r.e_pc      = e_pc;
        return r;
    endfunction

    // ---------------- stimulus ----------------
    vec_t tbl[30];

    initial begin
        bit          seen;
        int          got;
        logic [31:0] pcs[2];

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        cur_epoch = 0;
        mem_lat   = 1;
        m_req_pc  = RESET_PC;
        nv        = mk(0, 0, 0, 0, 0, 0, 0);
        i_nrst = 1'b0; i_ready = 1'b0; i_req_ready = 1'b0; i_rsp_valid = 1'b0;
        i_rsp_data = '0; i_con_redirect = 1'b0; i_addr_redirect = '0;

        // L=1 stream, decode stall for 10 cycles, request port stall
        tbl[0]  = mk(0, 1, 1, 0, 32'h0,  0, 32'h0);
        tbl[1]  = mk(1, 1, 1, 1, 32'h0,  0, 32'h0);
        tbl[2]  = mk(1, 1, 1, 1, 32'h4,  0, 32'h0);
        tbl[3]  = mk(1, 1, 1, 1, 32'h8,  1, 32'h0);
        tbl[4]  = mk(1, 1, 1, 1, 32'hC,  1, 32'h4);
        tbl[5]  = mk(1, 1, 1, 1, 32'h10, 1, 32'h8);
        tbl[6]  = mk(0, 0, 1, 0, 32'h0,  0, 32'h0);
        tbl[7]  = mk(1, 0, 1, 1, 32'h0,  0, 32'h0);
        tbl[8]  = mk(1, 0, 1, 1, 32'h4,  0, 32'h0);
        tbl[9]  = mk(1, 0, 1, 1, 32'h8,  1, 32'h0);
        tbl[10] = mk(1, 0, 1, 1, 32'hC,  1, 32'h0);
        for (int i = 11; i <= 16; i++) tbl[i] = mk(1, 0, 1, 0, 32'h0, 1, 32'h0);
        tbl[17] = mk(1, 1, 1, 0, 32'h0,  1, 32'h0);
        tbl[18] = mk(1, 1, 1, 1, 32'h10, 1, 32'h4);
        tbl[19] = mk(1, 1, 1, 1, 32'h14, 1, 32'h8);
        tbl[20] = mk(1, 1, 1, 1, 32'h18, 1, 32'hC);
        tbl[21] = mk(1, 1, 1, 1, 32'h1C, 1, 32'h10);
        tbl[22] = mk(0, 0, 1, 0, 32'h0,  0, 32'h0);
        for (int i = 23; i <= 27; i++) tbl[i] = mk(1, 0, 0, 1, 32'h0, 0, 32'h0);
        tbl[28] = mk(1, 0, 1, 1, 32'h0,  0, 32'h0);
        tbl[29] = mk(1, 0, 0, 1, 32'h4,  0, 32'h0);

        @(posedge i_clk);
        #1;
        for (int i = 0; i < 30; i++) begin
            step(tbl[i].nrst, tbl[i].ready, tbl[i].req_ready, 1'b0, 32'h0, 1'b1, 1'b1, tbl[i]);
        end

        // L=3: redirect to 0x100 with three requests in flight
        mem_lat = 3;
        go(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) go(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 32'h100, 1'b0, 1'b0, nv);
        go(1, 1, 1, 0, 0);
        chk("redir_valid_low", 32'(s_valid), 32'd0);
        chk("redir_req_valid", 32'(s_rv), 32'd1);
        chk("redir_req_addr", s_ra, 32'h100);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            go(1, 1, 1, 0, 0);
            if (s_valid && !seen) begin
                seen = 1'b1;
                chk("redir_first_pc", s_pc, 32'h100);
                chk("redir_first_lat", k, 3);
            end
        end
        chk("redir_first_seen", 32'(seen), 32'd1);

        // L=2: redirect, response and pop in one cycle with two entries queued
        mem_lat = 2;
        go(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) go(1, 0, 1, 0, 0);
        go(1, 1, 1, 1, 32'h200);
        chk("combo_pre_valid", 32'(s_valid), 32'd1);
        chk("combo_pre_pc", s_pc, 32'h0);
        go(1, 1, 1, 0, 0);
        chk("combo_valid_low", 32'(s_valid), 32'd0);
        chk("combo_req_addr", s_ra, 32'h200);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            go(1, 1, 1, 0, 0);
            if (s_valid && !seen) begin
                seen = 1'b1;
                chk("combo_first_pc", s_pc, 32'h200);
                chk("combo_first_lat", k, 2);
            end
        end
        chk("combo_first_seen", 32'(seen), 32'd1);

        // mid-stream reset, then redirect to the top of the address space
        go(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) go(1, 0, 1, 0, 0);
        chk("mid_pre_valid", 32'(s_valid), 32'd1);
        go(0, 0, 1, 0, 0);
        chk("mid_rst_valid", 32'(s_valid), 32'd0);
        chk("mid_rst_req_valid", 32'(s_rv), 32'd0);
        go(1, 0, 0, 0, 0);
        chk("mid_post_valid", 32'(s_valid), 32'd0);
        chk("mid_post_req_addr", s_ra, RESET_PC);
        go(1, 1, 1, 1, 32'hFFFF_FFFC);
        got = 0;
        for (int k = 0; k < 12; k++) begin
            go(1, 1, 1, 0, 0);
            if (s_valid && got < 2) begin
                pcs[got] = s_pc;
                got++;
            end
        end
        chk("wrap_count", got, 2);
        chk("wrap_pc0", pcs[0], 32'hFFFF_FFFC);
        chk("wrap_pc1", pcs[1], 32'h0);

        // randomized traffic against the model
        for (int b = 0; b < 15; b++) begin
            mem_lat = $urandom_range(1, 5);
            for (int i = 0; i < 200; i++) begin
                logic [31:0] ra;
                ra = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF4;
                step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, ra,
                     $urandom_range(0, 3) != 0, 1'b0, nv);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
